pipe_front_regs: RTL

- Sequential front end of the 5-stage RV32I pipeline: PC register, IF/ID register and ID/EX register.
- Applies the load-use stall/flush requests from the hazard detection unit and the EX-stage branch/jump redirect.
- Drives back the EX-stage destination/control fields that the hazard detection unit consumes (ex_rd_address, ex_reg_write, ex_mem_read), closing the loop.
- Also keeps stall and flush performance counters.

---
 rtl/pipe_front_regs.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/pipe_front_regs.sv
// pipe_front_regs: PC, IF/ID and ID/EX pipeline registers for the RV32I
// five-stage front end. It applies hazard-unit stall/flush requests and the
// EX-stage redirect, and counts stall cycles and redirect events.
// Every output is driven straight from a register.
module pipe_front_regs #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          CNT_W     = 32,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_stall_pc,
    input  logic             i_stall_if_id,
    input  logic             i_flush_id_ex,
    input  logic             i_ex_redirect,
    input  logic [31:0]      i_ex_redirect_pc,
    input  logic [31:0]      i_imem_instr,
    input  logic [4:0]       i_id_rs1_address,
    input  logic [4:0]       i_id_rs2_address,
    input  logic [4:0]       i_id_rd_address,
    input  logic             i_id_reg_write,
    input  logic             i_id_mem_read,
    input  logic             i_id_mem_write,
    input  logic [31:0]      i_id_rs1_data,
    input  logic [31:0]      i_id_rs2_data,
    input  logic [31:0]      i_id_imm,
    output logic [31:0]      o_if_pc,
    output logic [31:0]      o_id_pc,
    output logic [31:0]      o_id_instr,
    output logic             o_id_valid,
    output logic [31:0]      o_ex_pc,
    output logic [4:0]       o_ex_rs1_address,
    output logic [4:0]       o_ex_rs2_address,
    output logic [4:0]       o_ex_rd_address,
    output logic             o_ex_reg_write,
    output logic             o_ex_mem_read,
    output logic             o_ex_mem_write,
    output logic [31:0]      o_ex_rs1_data,
    output logic [31:0]      o_ex_rs2_data,
    output logic [31:0]      o_ex_imm,
    output logic             o_ex_valid,
    output logic [CNT_W-1:0] o_stall_count,
    output logic [CNT_W-1:0] o_flush_count
);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [31:0]      r_if_pc;
    logic [31:0]      r_id_pc;
    logic [31:0]      r_id_instr;
    logic             r_id_valid;
    logic [31:0]      r_ex_pc;
    logic [4:0]       r_ex_rs1_address;
    logic [4:0]       r_ex_rs2_address;
    logic [4:0]       r_ex_rd_address;
    logic             r_ex_reg_write;
    logic             r_ex_mem_read;
    logic             r_ex_mem_write;
    logic [31:0]      r_ex_rs1_data;
    logic [31:0]      r_ex_rs2_data;
    logic [31:0]      r_ex_imm;
    logic             r_ex_valid;
    logic [CNT_W-1:0] r_stall_count;
    logic [CNT_W-1:0] r_flush_count;

    // Fetch PC: redirect overrides any stall, otherwise advance by 4 unless held.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_if_pc <= RESET_PC;
        end else if (i_ex_redirect) begin
            r_if_pc <= i_ex_redirect_pc;
        end else if (i_stall_pc) begin
            r_if_pc <= r_if_pc;
        end else begin
            r_if_pc <= r_if_pc + 32'd4;
        end
    end

    // IF/ID: redirect kills the fetched instruction, stall holds, else capture fetch.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (i_ex_redirect) begin
            r_id_pc    <= 32'h0000_0000;
            r_id_instr <= NOP_INSTR;
            r_id_valid <= 1'b0;
        end else if (i_stall_if_id) begin
            r_id_pc    <= r_id_pc;
            r_id_instr <= r_id_instr;
            r_id_valid <= r_id_valid;
        end else begin
            r_id_pc    <= r_if_pc;
            r_id_instr <= i_imem_instr;
            r_id_valid <= 1'b1;
        end
    end

    // ID/EX: an all-zero bubble on redirect, flush or an empty IF/ID, so the
    // hazard unit can never match a bubble; otherwise take the decoded fields.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_ex_pc          <= 32'h0000_0000;
            r_ex_rs1_address <= 5'd0;
            r_ex_rs2_address <= 5'd0;
            r_ex_rd_address  <= 5'd0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_rs1_data    <= 32'h0000_0000;
            r_ex_rs2_data    <= 32'h0000_0000;
            r_ex_imm         <= 32'h0000_0000;
            r_ex_valid       <= 1'b0;
        end else if (i_ex_redirect || i_flush_id_ex || !r_id_valid) begin
            r_ex_pc          <= 32'h0000_0000;
            r_ex_rs1_address <= 5'd0;
            r_ex_rs2_address <= 5'd0;
            r_ex_rd_address  <= 5'd0;
            r_ex_reg_write   <= 1'b0;
            r_ex_mem_read    <= 1'b0;
            r_ex_mem_write   <= 1'b0;
            r_ex_rs1_data    <= 32'h0000_0000;
            r_ex_rs2_data    <= 32'h0000_0000;
            r_ex_imm         <= 32'h0000_0000;
            r_ex_valid       <= 1'b0;
        end else begin
            r_ex_pc          <= r_id_pc;
            r_ex_rs1_address <= i_id_rs1_address;
            r_ex_rs2_address <= i_id_rs2_address;
            r_ex_rd_address  <= i_id_rd_address;
            r_ex_reg_write   <= i_id_reg_write;
            r_ex_mem_read    <= i_id_mem_read;
            r_ex_mem_write   <= i_id_mem_write;
            r_ex_rs1_data    <= i_id_rs1_data;
            r_ex_rs2_data    <= i_id_rs2_data;
            r_ex_imm         <= i_id_imm;
            r_ex_valid       <= 1'b1;
        end
    end

    // Performance counters: a redirect cycle counts as a flush, never as a stall.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_stall_count <= {CNT_W{1'b0}};
            r_flush_count <= {CNT_W{1'b0}};
        end else if (i_ex_redirect) begin
            r_stall_count <= r_stall_count;
            r_flush_count <= r_flush_count + CNT_ONE;
        end else if (i_stall_pc) begin
            r_stall_count <= r_stall_count + CNT_ONE;
            r_flush_count <= r_flush_count;
        end else begin
            r_stall_count <= r_stall_count;
            r_flush_count <= r_flush_count;
        end
    end

    assign o_if_pc          = r_if_pc;
    assign o_id_pc          = r_id_pc;
    assign o_id_instr       = r_id_instr;
    assign o_id_valid       = r_id_valid;
    assign o_ex_pc          = r_ex_pc;
    assign o_ex_rs1_address = r_ex_rs1_address;
    assign o_ex_rs2_address = r_ex_rs2_address;
    assign o_ex_rd_address  = r_ex_rd_address;
    assign o_ex_reg_write   = r_ex_reg_write;
    assign o_ex_mem_read    = r_ex_mem_read;
    assign o_ex_mem_write   = r_ex_mem_write;
    assign o_ex_rs1_data    = r_ex_rs1_data;
    assign o_ex_rs2_data    = r_ex_rs2_data;
    assign o_ex_imm         = r_ex_imm;
    assign o_ex_valid       = r_ex_valid;
    assign o_stall_count    = r_stall_count;
    assign o_flush_count    = r_flush_count;

endmodule
